uart_tx_scheduler: RTL

Sequences the UART transmitter on behalf of the MIPS core. CPU stores to the memory-mapped TX-data address push bytes into a small FIFO. An FSM pops one byte at a time and drives the UART TX start/busy handshake, so software never stalls on the serial line. The block also exposes status (full/empty/count, sticky done and overflow flags), which the RAM address translator maps back for loads.

---
 rtl/uart_tx_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: byte FIFO between CPU stores and the UART transmitter.
// A four-state FSM pops one byte at a time and runs the tx_start/tx_busy
// handshake. Status (full/empty/count) and sticky flags are exposed for loads.
// Optional feature: define TX_ACK_TIMEOUT_EN to abandon a frame whose
// tx_busy acknowledge does not arrive within ACK_TIMEOUT cycles.
module uart_tx_scheduler #(
   parameter int UART_Nbit       = 8,
   parameter int FIFO_DEPTH_LOG2 = 2,
   parameter int ACK_TIMEOUT     = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [UART_Nbit-1:0]       wr_data,
   input  logic                       clr_tx_flag,
   input  logic                       tx_busy,
   output logic                       tx_start,
   output logic [UART_Nbit-1:0]       tx_data,
   output logic                       fifo_full,
   output logic                       fifo_empty,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
   output logic                       tx_flag,
   output logic                       overflow,
   output logic                       tx_timeout
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam logic [FIFO_DEPTH_LOG2:0] FULL_CNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

   if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
      $error("ACK_TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

   state_t                     state_q, state_d;
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
   logic [UART_Nbit-1:0]       mem_q [DEPTH];
   logic [UART_Nbit-1:0]       mem_d [DEPTH];
   logic [UART_Nbit-1:0]       tx_data_q, tx_data_d;
   logic                       tx_flag_q, tx_flag_d;
   logic                       overflow_q, overflow_d;
   logic                       full, empty, push, pop, flag_set;

`ifdef TX_ACK_TIMEOUT_EN
   localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
   logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
   logic             tx_timeout_q, tx_timeout_d;
   logic             timeout_set;
`endif

   assign full       = (count_q == FULL_CNT);
   assign empty      = (count_q == '0);
   assign fifo_full  = full;
   assign fifo_empty = empty;
   assign fifo_count = count_q;
   assign tx_start   = (state_q == START);
   assign tx_data    = tx_data_q;
   assign tx_flag    = tx_flag_q;
   assign overflow   = overflow_q;

   // FSM next state: pop in IDLE, pulse in START, then follow tx_busy up and down
   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      flag_set  = 1'b0;
      tx_data_d = tx_data_q;
`ifdef TX_ACK_TIMEOUT_EN
      ack_cnt_d   = ack_cnt_q;
      timeout_set = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (!empty && !tx_busy) begin
               pop       = 1'b1;
               tx_data_d = mem_q[rd_ptr_q];
               state_d   = START;
            end
         end
         START: begin
            state_d = WAIT_ACK;
`ifdef TX_ACK_TIMEOUT_EN
            ack_cnt_d = '0;
`endif
         end
         WAIT_ACK: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
`ifdef TX_ACK_TIMEOUT_EN
            end else if (ack_cnt_q == ACK_LAST) begin
               // popped byte is dropped, not re-queued
               timeout_set = 1'b1;
               state_d     = IDLE;
            end else begin
               ack_cnt_d = ack_cnt_q + 1'b1;
`endif
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               flag_set = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO bookkeeping and sticky flags; a set event beats a same-cycle clear
   always_comb begin
      push     = wr_en && (!full || pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      tx_flag_d  = flag_set || (tx_flag_q && !clr_tx_flag);
      overflow_d = (wr_en && full && !pop) || (overflow_q && !clr_tx_flag);
`ifdef TX_ACK_TIMEOUT_EN
      tx_timeout_d = timeout_set || (tx_timeout_q && !clr_tx_flag);
`endif
   end

   // control and status registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tx_data_q  <= '0;
         tx_flag_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tx_data_q  <= tx_data_d;
         tx_flag_q  <= tx_flag_d;
         overflow_q <= overflow_d;
      end
   end

   // FIFO storage; contents are meaningless until written, so no reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef TX_ACK_TIMEOUT_EN
   // acknowledge timeout counter and sticky flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_cnt_q    <= '0;
         tx_timeout_q <= 1'b0;
      end else begin
         ack_cnt_q    <= ack_cnt_d;
         tx_timeout_q <= tx_timeout_d;
      end
   end
   assign tx_timeout = tx_timeout_q;
`else
   assign tx_timeout = 1'b0;
`endif

endmodule
